// File: rtl/body_regfile.sv
// rtl/body_regfile.sv - body-state word store shared by the host bus and the simulation FSM
//
// Purpose:
//   Flop-based word store (WORDS x 32) holding G, body count, start/status and
//   the per-body MASS/RAD/POS/VEL/ACC fields. The FSM gets two independent
//   read/write triples (A = ADDR1-3, B = ADDR4-6); the host gets a simple
//   Avalon-MM slave port plus a start/done handshake.
//
// Ports:
//   CLK, RESET                 clock, async active-high reset
//   FSM_re[1:0], FSM_we[1:0]   per-triple read / write enables (bit0 = A, bit1 = B)
//   ADDR1..ADDR6, DATA1..DATA6 FSM word addresses and write data
//   DATA1in..DATA6in           FSM read data, registered, held between reads
//   clear_accs                 zero every ACC_X/Y/Z word
//   FSM_DONE, FSM_START        step-finished input, one-cycle start pulse output
//   G, PLANET_NUM              words 0 and 1, continuous
//   AVL_CS/READ/WRITE/ADDR/WRITEDATA/READDATA   host slave port, read latency 1

module body_regfile #(
  parameter int MAX_BODIES = 10,
  parameter int WORDS      = 114
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [1:0]  FSM_re,
  input  logic [1:0]  FSM_we,
  input  logic [31:0] ADDR1,
  input  logic [31:0] ADDR2,
  input  logic [31:0] ADDR3,
  input  logic [31:0] ADDR4,
  input  logic [31:0] ADDR5,
  input  logic [31:0] ADDR6,
  input  logic [31:0] DATA1,
  input  logic [31:0] DATA2,
  input  logic [31:0] DATA3,
  input  logic [31:0] DATA4,
  input  logic [31:0] DATA5,
  input  logic [31:0] DATA6,
  output logic [31:0] DATA1in,
  output logic [31:0] DATA2in,
  output logic [31:0] DATA3in,
  output logic [31:0] DATA4in,
  output logic [31:0] DATA5in,
  output logic [31:0] DATA6in,
  input  logic        clear_accs,
  input  logic        FSM_DONE,
  output logic        FSM_START,
  output logic [31:0] G,
  output logic [31:0] PLANET_NUM,
  input  logic        AVL_CS,
  input  logic        AVL_READ,
  input  logic        AVL_WRITE,
  input  logic [6:0]  AVL_ADDR,
  input  logic [31:0] AVL_WRITEDATA,
  output logic [31:0] AVL_READDATA
);

  localparam int          AW       = $clog2(WORDS);
  localparam int          ACC_BASE = 4 + 8 * MAX_BODIES;
  localparam logic [31:0] WORDS_W  = 32'(WORDS);

  logic [31:0] mem  [WORDS];
  logic [31:0] addr [6];
  logic [31:0] wdat [6];
  logic [31:0] rdq  [6];

  logic running;
  logic done;
  logic done_q;
  logic host_rd;
  logic host_wr;
  logic host_store;
  logic start_req;
  logic done_rise;

  // Flatten the six FSM ports so both triples share one loop body.
  assign addr[0] = ADDR1;
  assign addr[1] = ADDR2;
  assign addr[2] = ADDR3;
  assign addr[3] = ADDR4;
  assign addr[4] = ADDR5;
  assign addr[5] = ADDR6;
  assign wdat[0] = DATA1;
  assign wdat[1] = DATA2;
  assign wdat[2] = DATA3;
  assign wdat[3] = DATA4;
  assign wdat[4] = DATA5;
  assign wdat[5] = DATA6;

  assign DATA1in = rdq[0];
  assign DATA2in = rdq[1];
  assign DATA3in = rdq[2];
  assign DATA4in = rdq[3];
  assign DATA5in = rdq[4];
  assign DATA6in = rdq[5];

  assign G          = mem[0];
  assign PLANET_NUM = mem[1];

  assign host_rd   = AVL_CS & AVL_READ;
  assign host_wr   = AVL_CS & AVL_WRITE;
  assign done_rise = FSM_DONE & ~done_q;

  // A start is only honoured from idle; a second start while running is ignored.
  assign start_req = host_wr && (AVL_ADDR == 7'd2) && (AVL_WRITEDATA != 32'd0) && !running;

  // START/STATUS are not backed by storage from the host side, and the body
  // data is frozen against the host while a step is running.
  assign host_store = host_wr && !running &&
                      (AVL_ADDR != 7'd2) && (AVL_ADDR != 7'd3) &&
                      (32'(AVL_ADDR) < WORDS_W);

  function automatic logic [31:0] fsm_word(input logic [31:0] a);
    if (a < WORDS_W) return mem[a[AW-1:0]];
    return '0;
  endfunction

  // Later assignments override earlier ones, which yields the write priority
  // host < clear_accs < triple A < triple B on any colliding word.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < WORDS; i++) mem[i] <= '0;
    end else begin
      if (host_store) mem[AVL_ADDR[AW-1:0]] <= AVL_WRITEDATA;
      if (clear_accs) begin
        for (int i = ACC_BASE; i < WORDS; i++) mem[i] <= '0;
      end
      for (int p = 0; p < 6; p++) begin
        if (FSM_we[p / 3] && (addr[p] < WORDS_W)) mem[addr[p][AW-1:0]] <= wdat[p];
      end
    end
  end

  // Reads sample the pre-edge array, so read-during-write returns the old word.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int p = 0; p < 6; p++) rdq[p] <= '0;
    end else begin
      for (int p = 0; p < 6; p++) begin
        if (FSM_re[p / 3]) rdq[p] <= fsm_word(addr[p]);
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      AVL_READDATA <= '0;
    end else if (host_rd) begin
      if (AVL_ADDR == 7'd2)                AVL_READDATA <= '0;
      else if (AVL_ADDR == 7'd3)           AVL_READDATA <= {30'b0, running, done};
      else if (32'(AVL_ADDR) < WORDS_W)    AVL_READDATA <= mem[AVL_ADDR[AW-1:0]];
      else                                 AVL_READDATA <= '0;
    end
  end

  // Start/done handshake; a start in the same cycle as a done edge wins.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      running   <= 1'b0;
      done      <= 1'b0;
      done_q    <= 1'b0;
      FSM_START <= 1'b0;
    end else begin
      done_q    <= FSM_DONE;
      FSM_START <= start_req;
      if (start_req) begin
        running <= 1'b1;
        done    <= 1'b0;
      end else if (done_rise) begin
        running <= 1'b0;
        done    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_body_regfile.sv
// tb/tb_body_regfile.sv - scoreboard bench for body_regfile with a word-array reference model

module tb_body_regfile;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [1:0]  FSM_re, FSM_we;
  logic [31:0] ADDR1, ADDR2, ADDR3, ADDR4, ADDR5, ADDR6;
  logic [31:0] DATA1, DATA2, DATA3, DATA4, DATA5, DATA6;
  logic [31:0] DATA1in, DATA2in, DATA3in, DATA4in, DATA5in, DATA6in;
  logic        clear_accs, FSM_DONE, FSM_START;
  logic [31:0] G, PLANET_NUM;
  logic        AVL_CS, AVL_READ, AVL_WRITE;
  logic [6:0]  AVL_ADDR;
  logic [31:0] AVL_WRITEDATA, AVL_READDATA;

  always #5 CLK = ~CLK;

  body_regfile dut (
    .CLK(CLK), .RESET(RESET), .FSM_re(FSM_re), .FSM_we(FSM_we),
    .ADDR1(ADDR1), .ADDR2(ADDR2), .ADDR3(ADDR3), .ADDR4(ADDR4), .ADDR5(ADDR5), .ADDR6(ADDR6),
    .DATA1(DATA1), .DATA2(DATA2), .DATA3(DATA3), .DATA4(DATA4), .DATA5(DATA5), .DATA6(DATA6),
    .DATA1in(DATA1in), .DATA2in(DATA2in), .DATA3in(DATA3in),
    .DATA4in(DATA4in), .DATA5in(DATA5in), .DATA6in(DATA6in),
    .clear_accs(clear_accs), .FSM_DONE(FSM_DONE), .FSM_START(FSM_START),
    .G(G), .PLANET_NUM(PLANET_NUM),
    .AVL_CS(AVL_CS), .AVL_READ(AVL_READ), .AVL_WRITE(AVL_WRITE), .AVL_ADDR(AVL_ADDR),
    .AVL_WRITEDATA(AVL_WRITEDATA), .AVL_READDATA(AVL_READDATA)
  );

  typedef struct packed {
    logic [31:0]      avl;
    logic [5:0][31:0] d;
    logic             start;
    logic [31:0]      g;
    logic [31:0]      pn;
  } rec_t;

  rec_t sb[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model: the map as a plain word array plus handshake flags.
  logic [31:0]      m [114];
  bit               run_m, done_m, dprev_m;
  logic [31:0]      avl_m;
  logic [5:0][31:0] d_m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 114; i++) m[i] = '0;
    run_m = 0; done_m = 0; dprev_m = 0; avl_m = '0; d_m = '0;
  endtask

  function automatic logic [31:0] word_rd(input logic [31:0] a);
    if (a < 114) return m[a[6:0]];
    return '0;
  endfunction

  function automatic logic [31:0] host_rd(input logic [6:0] a);
    if (a == 2) return '0;
    if (a == 3) return {30'b0, run_m, done_m};
    return word_rd({25'b0, a});
  endfunction

  // Apply the current inputs to the model for one edge, push the expected
  // post-edge outputs, then advance to the next falling edge.
  task automatic step();
    logic [31:0] a [6];
    logic [31:0] dd [6];
    bit start, rise;
    rec_t r;
    a[0] = ADDR1; a[1] = ADDR2; a[2] = ADDR3; a[3] = ADDR4; a[4] = ADDR5; a[5] = ADDR6;
    dd[0] = DATA1; dd[1] = DATA2; dd[2] = DATA3; dd[3] = DATA4; dd[4] = DATA5; dd[5] = DATA6;
    if (AVL_CS && AVL_READ) avl_m = host_rd(AVL_ADDR);
    for (int p = 0; p < 6; p++) if (FSM_re[p / 3]) d_m[p] = word_rd(a[p]);
    start = AVL_CS && AVL_WRITE && AVL_ADDR == 2 && AVL_WRITEDATA != 0 && !run_m;
    rise  = FSM_DONE && !dprev_m;
    if (AVL_CS && AVL_WRITE && !run_m && AVL_ADDR != 2 && AVL_ADDR != 3 && AVL_ADDR < 114)
      m[AVL_ADDR] = AVL_WRITEDATA;
    if (clear_accs) for (int k = 84; k < 114; k++) m[k] = '0;
    for (int p = 0; p < 6; p++) if (FSM_we[p / 3] && a[p] < 114) m[a[p][6:0]] = dd[p];
    if (start) begin run_m = 1; done_m = 0; end
    else if (rise) begin run_m = 0; done_m = 1; end
    dprev_m = FSM_DONE;
    r.avl = avl_m; r.d = d_m; r.start = start; r.g = m[0]; r.pn = m[1];
    sb.push_back(r);
    @(posedge CLK);
    @(negedge CLK);
  endtask

  initial begin : monitor
    rec_t r;
    forever begin
      @(posedge CLK);
      #1;
      if (sb.size() > 0) begin
        r = sb.pop_front();
        chk("avl_readdata", AVL_READDATA, r.avl);
        chk("data1in", DATA1in, r.d[0]);
        chk("data2in", DATA2in, r.d[1]);
        chk("data3in", DATA3in, r.d[2]);
        chk("data4in", DATA4in, r.d[3]);
        chk("data5in", DATA5in, r.d[4]);
        chk("data6in", DATA6in, r.d[5]);
        chk("fsm_start", {31'b0, FSM_START}, {31'b0, r.start});
        chk("g", G, r.g);
        chk("planet_num", PLANET_NUM, r.pn);
      end
    end
  end

  task automatic idle();
    FSM_re = 0; FSM_we = 0; clear_accs = 0;
    ADDR1 = 0; ADDR2 = 0; ADDR3 = 0; ADDR4 = 0; ADDR5 = 0; ADDR6 = 0;
    DATA1 = 0; DATA2 = 0; DATA3 = 0; DATA4 = 0; DATA5 = 0; DATA6 = 0;
    AVL_CS = 0; AVL_READ = 0; AVL_WRITE = 0; AVL_ADDR = 0; AVL_WRITEDATA = 0;
  endtask

  task automatic host_write(input logic [6:0] a, input logic [31:0] d);
    AVL_CS = 1; AVL_WRITE = 1; AVL_ADDR = a; AVL_WRITEDATA = d;
    step();
    AVL_CS = 0; AVL_WRITE = 0;
  endtask

  task automatic host_read(input logic [6:0] a);
    AVL_CS = 1; AVL_READ = 1; AVL_ADDR = a;
    step();
    AVL_CS = 0; AVL_READ = 0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_data1in"}, DATA1in, 0);
    chk({tag, "_data4in"}, DATA4in, 0);
    chk({tag, "_data6in"}, DATA6in, 0);
    chk({tag, "_avl"}, AVL_READDATA, 0);
    chk({tag, "_start"}, {31'b0, FSM_START}, 0);
    chk({tag, "_g"}, G, 0);
    chk({tag, "_pn"}, PLANET_NUM, 0);
  endtask

  function automatic logic [31:0] rnd_fsm_addr();
    int r = $urandom_range(0, 15);
    if (r == 0) return 32'(114 + $urandom_range(0, 1000));
    if (r < 8)  return 32'(80 + $urandom_range(0, 15));
    return 32'(4 + $urandom_range(0, 109));
  endfunction

  initial begin : stim
    idle();
    FSM_DONE = 0;
    RESET = 1;
    model_reset();
    #12;
    check_all_zero("reset");
    @(negedge CLK);
    RESET = 0;

    // 1: G and body count
    host_write(0, 32'h41200000);
    host_write(1, 32'd4);
    host_read(1);

    // 2: host-loaded POS_X read back through triple A
    host_write(24, 32'h3f800000);
    FSM_re = 2'b01; ADDR1 = 24;
    step();
    idle();
    step();

    // 3: triple B beats triple A beats clear_accs on word 84
    for (int k = 84; k < 114; k++) host_write(7'(k), 32'h1000 + 32'(k));
    FSM_we = 2'b11; ADDR1 = 84; ADDR4 = 84; DATA1 = 32'h1; DATA4 = 32'h2;
    ADDR2 = 200; ADDR3 = 200; ADDR5 = 200; ADDR6 = 200; clear_accs = 1;
    step();
    idle();
    for (int k = 84; k < 114; k++) host_read(7'(k));

    // 4: start handshake gates host writes
    host_write(2, 32'd1);
    step();
    host_read(3);
    host_write(30, 32'h12345678);
    host_read(30);
    host_write(2, 32'd5);
    FSM_DONE = 1; step();
    FSM_DONE = 0; step();
    host_read(3);
    host_read(2);
    host_write(30, 32'h12345678);
    host_read(30);
    host_write(3, 32'hffffffff);
    host_read(3);

    // start coinciding with a done edge: start wins
    FSM_DONE = 1;
    host_write(2, 32'd7);
    host_read(3);
    FSM_DONE = 0; step();
    FSM_DONE = 1; step();
    FSM_DONE = 0; host_read(3);

    // simultaneous host read and write returns the old value
    AVL_CS = 1; AVL_READ = 1; AVL_WRITE = 1; AVL_ADDR = 40; AVL_WRITEDATA = 32'hcafef00d;
    step();
    idle();
    host_read(40);

    // 5: out-of-range read, read-during-write on triple B
    host_write(113, 32'h55aa55aa);
    FSM_re = 2'b11; ADDR1 = 200; ADDR4 = 113;
    FSM_we = 2'b10; DATA4 = 32'hdeadbeef;
    ADDR5 = 300; ADDR6 = 300;
    step();
    idle();
    FSM_re = 2'b10; ADDR4 = 113;
    step();
    idle();
    FSM_we = 2'b01; ADDR1 = 500; ADDR2 = 114; ADDR3 = 114; DATA1 = 32'hbad;
    step();
    idle();

    // random phase
    for (int c = 0; c < 400; c++) begin
      FSM_re = 2'($urandom_range(0, 3));
      FSM_we = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      ADDR1 = rnd_fsm_addr(); ADDR2 = rnd_fsm_addr(); ADDR3 = rnd_fsm_addr();
      ADDR4 = rnd_fsm_addr(); ADDR5 = rnd_fsm_addr(); ADDR6 = rnd_fsm_addr();
      DATA1 = $urandom; DATA2 = $urandom; DATA3 = $urandom;
      DATA4 = $urandom; DATA5 = $urandom; DATA6 = $urandom;
      clear_accs = ($urandom_range(0, 15) == 0);
      AVL_CS = $urandom_range(0, 3) != 0;
      AVL_READ = 1'($urandom_range(0, 1));
      AVL_WRITE = 1'($urandom_range(0, 1));
      AVL_ADDR = 7'($urandom_range(0, 127));
      AVL_WRITEDATA = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 7) == 0) FSM_DONE = ~FSM_DONE;
      step();
    end
    idle();
    FSM_DONE = 0;
    step();

    // 6: async reset in the middle of a running step
    host_write(0, 32'h40000000);
    host_write(2, 32'd1);
    FSM_re = 2'b11; ADDR1 = 0; ADDR4 = 0;
    host_read(0);
    idle();
    #2;
    RESET = 1;
    #1;
    check_all_zero("midreset");
    @(posedge CLK);
    @(negedge CLK);
    RESET = 0;
    model_reset();
    host_read(3);
    host_read(0);
    step();

    chk("sb_drain", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
